// File: rtl/rv_ram_pkg.sv
// Shared definitions for the clearable dual-port RAM family.
//   RDW_OLD / RDW_NEW : read-during-write modes (pre-write data / write-through)
//   clr_state_e       : clear engine state encoding
package rv_ram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/rv_ram_clr_fsm.sv
// Sequential clear engine: walks every entry once, one per cycle, after reset
// release or a clear request.
//   clk, reset (sync, active-low), clear (start pass when idle)
//   clr_we   : write INIT value to clr_addr this cycle
//   clr_addr : entry being cleared
//   busy     : registered, high while a pass is in progress or reset is held
module rv_ram_clr_fsm
    import rv_ram_pkg::*;
#(
    parameter int unsigned SIZE  = 64,
    parameter int unsigned ADDRW = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic             clr_we,
    output logic [ADDRW-1:0] clr_addr,
    output logic             busy
);

    clr_state_e       state_q, state_d;
    logic [ADDRW-1:0] clr_ptr_q, clr_ptr_d;
    logic             busy_q, busy_d;
    logic             last_entry;

    assign last_entry = (clr_ptr_q == ADDRW'(SIZE - 1));

    // Next-state: clear is only looked at in IDLE, so a pass cannot restart.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDRW'(1);
                if (last_entry) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_ptr_d = '0;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Reset parks the engine at the start of a pass, so release always
    // triggers a full initialisation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // No array writes while reset is held.
    assign clr_we   = (state_q == CLEAR) && reset;
    assign clr_addr = clr_ptr_q;
    assign busy     = busy_q;

endmodule

// File: rtl/rv_clr_dp_ram.sv
// Simple dual-port RAM with per-lane write enables, read valid handshake,
// optional output register, selectable read-during-write and a sequential
// clear engine that writes INIT_VAL to one entry per cycle.
//   clk, reset (sync, active-low), clear (start clear pass), busy
//   wren/waddr/wdata : write port, one enable per WORDW-bit lane
//   rden/raddr       : read request, accepted only when idle
//   rdata/rvalid     : read result (same cycle if OUT_REG=0, next cycle if 1)
module rv_clr_dp_ram
    import rv_ram_pkg::*;
#(
    parameter int unsigned      DATAW    = 32,
    parameter int unsigned      SIZE     = 64,
    parameter int unsigned      WORDW    = 8,
    parameter int unsigned      OUT_REG  = 1,
    parameter int unsigned      RDW_MODE = RDW_OLD,
    parameter logic [DATAW-1:0] INIT_VAL = '0,
    parameter int unsigned      ADDRW    = $clog2(SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     busy,
    input  logic [DATAW/WORDW-1:0]   wren,
    input  logic [ADDRW-1:0]         waddr,
    input  logic [DATAW-1:0]         wdata,
    input  logic                     rden,
    input  logic [ADDRW-1:0]         raddr,
    output logic [DATAW-1:0]         rdata,
    output logic                     rvalid
);

    localparam int unsigned BYTEENW = DATAW / WORDW;

    if ((DATAW % WORDW) != 0) begin : g_bad_lane_cfg
        $error("rv_clr_dp_ram: DATAW must be a multiple of WORDW");
    end

    logic               clr_we;
    logic [ADDRW-1:0]   clr_addr;
    logic               idle;
    logic               wr_in_rng, rd_in_rng;
    logic               wr_acc, rd_acc, rd_collide;
    logic [BYTEENW-1:0] mem_we;
    logic [ADDRW-1:0]   mem_addr;
    logic [DATAW-1:0]   mem_wdata;
    logic [DATAW-1:0]   rd_old, rd_val;
    logic [DATAW-1:0]   mem_q [SIZE];

    rv_ram_clr_fsm #(
        .SIZE  (SIZE),
        .ADDRW (ADDRW)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    assign idle      = reset & ~busy;
    assign wr_in_rng = {1'b0, waddr} < (ADDRW + 1)'(SIZE);
    assign rd_in_rng = {1'b0, raddr} < (ADDRW + 1)'(SIZE);
    assign wr_acc    = idle & wr_in_rng;
    assign rd_acc    = idle & rden;
    assign rd_collide = wr_acc & (|wren) & (waddr == raddr);

    // Clear engine owns the write port while it runs; user writes are dropped.
    always_comb begin
        mem_we    = '0;
        mem_addr  = waddr;
        mem_wdata = wdata;
        if (clr_we) begin
            mem_we    = '1;
            mem_addr  = clr_addr;
            mem_wdata = INIT_VAL;
        end else if (wr_acc) begin
            mem_we = wren;
        end
    end

    // Single storage process so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BYTEENW); i++) begin
            if (mem_we[i]) begin
                mem_q[mem_addr][i*WORDW +: WORDW] <= mem_wdata[i*WORDW +: WORDW];
            end
        end
    end

    assign rd_old = rd_in_rng ? mem_q[raddr] : '0;

    // Write-through merges only the lanes being written this cycle.
    always_comb begin
        rd_val = rd_old;
        if ((RDW_MODE == RDW_NEW) && rd_collide) begin
            for (int i = 0; i < int'(BYTEENW); i++) begin
                if (wren[i]) begin
                    rd_val[i*WORDW +: WORDW] = wdata[i*WORDW +: WORDW];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATAW-1:0] rdata_q;
        logic             rvalid_q;

        // rdata holds its last value between accepted reads.
        always_ff @(posedge clk) begin
            if (!reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= rd_val;
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end else begin : g_out_comb
        assign rdata  = rd_val;
        assign rvalid = rd_acc;
    end

endmodule

// File: tb/tb_rv_clr_dp_ram.sv
// Bench for rv_clr_dp_ram: two instances driven by shared stimulus.
//   dut_a: SIZE 64, registered read, read-old, INIT 0
//   dut_b: SIZE 48, combinational read, write-through, INIT 0xDEADBEEF
module tb_rv_clr_dp_ram;

    localparam int unsigned DW = 32;
    localparam int unsigned SA = 64;
    localparam int unsigned SB = 48;
    localparam int unsigned AW = 6;
    localparam logic [DW-1:0] INIT_B = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          reset, clear, rden;
    logic [3:0]    wren;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic          busy_a, busy_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;

    always #5 clk = ~clk;

    rv_clr_dp_ram #(
        .DATAW(DW), .SIZE(SA), .WORDW(8), .OUT_REG(1), .RDW_MODE(0),
        .INIT_VAL(32'h0)
    ) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_a),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .rden(rden), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
    );

    rv_clr_dp_ram #(
        .DATAW(DW), .SIZE(SB), .WORDW(8), .OUT_REG(0), .RDW_MODE(1),
        .INIT_VAL(INIT_B)
    ) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_b),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .rden(rden), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] mdl_a [SA];
    logic [DW-1:0] mdl_b [SB];
    int            left_a = SA;
    int            left_b = SB;
    logic          pend_a = 1'b0;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] en);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (en[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    // One clock cycle. Entered at posedge+1 with inputs set for the cycle.
    task automatic step();
        logic acc_a, acc_b, wa, wb;
        logic [DW-1:0] ea, eb, e;
        acc_a = reset && (left_a == 0) && rden;
        acc_b = reset && (left_b == 0) && rden;
        wa    = reset && (left_a == 0) && (int'(waddr) < int'(SA));
        wb    = reset && (left_b == 0) && (int'(waddr) < int'(SB));
        ea    = mdl_a[raddr];
        eb    = (int'(raddr) < int'(SB)) ? mdl_b[raddr] : '0;
        if (wb && (waddr == raddr)) eb = merge(eb, wdata, wren);
        if (acc_a) qa.push_back(ea);
        if (acc_b) qb.push_back(eb);
        #1;
        chk("busy_a", 32'(busy_a), 32'(left_a != 0));
        chk("busy_b", 32'(busy_b), 32'(left_b != 0));
        chk("rvalid_b", 32'(rvalid_b), 32'(acc_b));
        if (acc_b) chk("rdata_b", rdata_b, qb.pop_front());
        @(posedge clk);
        if (!reset) begin
            left_a = SA;
            left_b = SB;
            last_a = '0;
        end else begin
            if (left_a > 0) begin
                mdl_a[SA - left_a] = '0;
                left_a--;
            end else begin
                if (wa) mdl_a[waddr] = merge(mdl_a[waddr], wdata, wren);
                if (clear) left_a = SA;
            end
            if (left_b > 0) begin
                mdl_b[SB - left_b] = INIT_B;
                left_b--;
            end else begin
                if (wb) mdl_b[waddr] = merge(mdl_b[waddr], wdata, wren);
                if (clear) left_b = SB;
            end
        end
        pend_a = acc_a;
        #1;
        chk("rvalid_a", 32'(rvalid_a), 32'(pend_a));
        if (pend_a) begin
            e = qa.pop_front();
            last_a = e;
            chk("rdata_a", rdata_a, e);
        end else begin
            chk("rhold_a", rdata_a, last_a);
        end
    endtask

    task automatic quiet();
        rden = 1'b0; wren = '0; clear = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] en);
        waddr = AW'(a); wdata = d; wren = en;
        step();
        wren = '0;
    endtask

    task automatic rd(input int a);
        raddr = AW'(a); rden = 1'b1;
        step();
        rden = 1'b0;
    endtask

    task automatic wr_rd(input int a, input logic [DW-1:0] d, input logic [3:0] en);
        waddr = AW'(a); raddr = AW'(a); wdata = d; wren = en; rden = 1'b1;
        step();
        wren = '0; rden = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 200) begin
            step();
            n++;
        end
        if (busy_a || busy_b) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic count_busy_a(input string tag);
        int cnt;
        cnt = 0;
        while (busy_a && cnt < 200) begin
            cnt++;
            step();
        end
        chk(tag, 32'(cnt), 32'(SA));
    endtask

    initial begin
        for (int i = 0; i < int'(SA); i++) mdl_a[i] = '0;
        for (int i = 0; i < int'(SB); i++) mdl_b[i] = '0;
        reset = 1'b0; waddr = '0; raddr = '0; wdata = '0;
        quiet();
        @(posedge clk);
        #1;

        // Reset held for three edges, then full initialisation pass
        step();
        step();
        reset = 1'b1;
        count_busy_a("busy_len_after_reset");
        wait_idle();
        rd(0); rd(31); rd(63);
        step();

        // Out-of-range for the 48-entry instance
        wr(50, 32'h12345678, 4'hF);
        rd(50);

        // Byte lanes
        wr(5, 32'hAABBCCDD, 4'b1111);
        wr(5, 32'h11223344, 4'b0101);
        rd(5);
        step();
        chk("lanes_a", rdata_a, 32'hAA22CC44);

        // Read-during-write, full and partial
        wr(9, 32'h1, 4'hF);
        wr_rd(9, 32'h2, 4'hF);
        wr_rd(9, 32'hFFFFFFFF, 4'b0011);
        rd(9);

        // Back-to-back reads of 0..7
        for (int i = 0; i < 8; i++) wr(i, 32'h0100_0000 + 32'(i * 17), 4'hF);
        for (int i = 0; i < 8; i++) begin
            raddr = AW'(i); rden = 1'b1;
            step();
        end
        rden = 1'b0;
        step();

        // Clear mid-traffic: write and reads during busy are dropped
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr(3, 32'h5, 4'hF);
        rd(3); rd(4);
        wait_idle();
        rd(3);
        step();

        // Reset at pointer 20 restarts the pass; reads attempted throughout
        clear = 1'b1;
        step();
        clear = 1'b0;
        rden = 1'b1;
        for (int i = 0; i < 20; i++) begin
            raddr = AW'(i);
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        count_busy_a("busy_len_mid_reset");
        rden = 1'b0;
        wait_idle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rden  = 1'($urandom_range(0, 1));
            raddr = AW'($urandom_range(0, 63));
            wren  = 4'($urandom_range(0, 15));
            waddr = ($urandom_range(0, 3) == 0) ? raddr : AW'($urandom_range(0, 63));
            wdata = $urandom;
            clear = ($urandom_range(0, 63) == 0);
            step();
        end
        quiet();
        wait_idle();
        step();

        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_clr_dp_ram.md
# rv_clr_dp_ram

Parametrised successor to the team's simple dual-port RAM. It adds four things:
- configurable byte-lane granularity;
- a read-enable/valid handshake with optional output register;
- selectable read-during-write behaviour;
- a sequential clear engine that initialises one entry per cycle instead of a single-cycle array reset.

It serves as the storage primitive for warp-level register banks, tag arrays and scoreboards where a synthesizable, BRAM-inferable clear is required.

## Interface
- DATAW, 32, word width; must be a multiple of WORDW
- SIZE, 64, number of entries; any value ≥ 2, power of two not required
- WORDW, 8, write-enable lane width; BYTEENW = DATAW/WORDW (WORDW = DATAW gives one enable)
- OUT_REG, 1, 0 = combinational read, 1 = registered read
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read-old, 1 = write-through
- INIT_VAL, 0, DATAW-wide value written by the clear engine
- ADDRW, $clog2(SIZE), address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- clear  in  1  start a clear pass (pulse; level is sampled only when idle)
- busy  out  1  clear pass in progress or reset asserted
- wren  in  BYTEENW  per-lane write enable
- waddr  in  ADDRW  write address
- wdata  in  DATAW  write data
- rden  in  1  read request
- raddr  in  ADDRW  read address
- rdata  out  DATAW  read data
- rvalid  out  1  rdata valid for the accepted read

## Operation
- FSM states: IDLE and CLEAR, plus a pointer clr_ptr[ADDRW-1:0].
- While reset = 0:
  - state ← CLEAR, clr_ptr ← 0, busy = 1, rvalid = 0;
  - rdata register ← 0 when OUT_REG = 1;
  - no array writes.
- CLEAR state, reset = 1:
  - each cycle writes INIT_VAL to entry clr_ptr, then clr_ptr++;
  - the cycle that writes SIZE-1 transitions to IDLE.
- IDLE: clear = 1 → CLEAR with clr_ptr = 0. clear is ignored while in CLEAR; there is no restart.
- Writes: accepted only in IDLE. Lane i (bits [i*WORDW +: WORDW]) is updated iff wren[i]. Writes during CLEAR are dropped silently.
- Reads: accepted iff rden = 1 and state = IDLE; otherwise rvalid stays 0.
- Out-of-range addresses (≥ SIZE):
  - write is dropped;
  - read returns 0 with rvalid asserted normally.
- Read-during-write (same address, same cycle, both accepted):
  - RDW_MODE 0 returns pre-write contents;
  - RDW_MODE 1 returns the merge of new lanes where wren = 1 and old lanes elsewhere.
- With OUT_REG = 1, rdata holds its last value when no read is accepted.

## Timing
- OUT_REG = 0: rdata and rvalid are combinational in the request cycle (rvalid = rden & ~busy).
- OUT_REG = 1: rdata and rvalid are registered, one cycle after the request. Reads are fully pipelined at one per cycle.
- Reset released at edge k: clear writes occur in cycles k … k+SIZE-1, and busy = 0 from cycle k+SIZE. The first read is accepted in cycle k+SIZE.
- clear sampled at edge t in IDLE: busy = 1 from t+1 through t+SIZE, and the pass takes SIZE cycles.
- busy is registered; the state is never observable combinationally from clear.
- Reset asserted mid-pass: the pointer returns to 0 and the full pass repeats after release.
- A write is visible to a non-colliding read in the following cycle.

## Structure
- Shared package rv_ram_pkg:
  - RDW_OLD = 0, RDW_NEW = 1;
  - clear FSM state encoding: IDLE = 1'b0, CLEAR = 1'b1.
- One sub-module, rv_ram_clr_fsm:
  - owns state, clr_ptr and busy;
  - outputs clr_we, clr_addr, busy.
- The top level muxes the clear port onto the write port. The array is kept in a single always block so it infers block RAM.
- Elaboration check: DATAW % WORDW == 0; otherwise $error.

## Test plan
- Reset with SIZE = 64: hold reset = 0 for 3 cycles, then release. busy must stay 1 for exactly 64 cycles after release. Reads of addresses 0, 31 and 63 then return 0x00000000 with rvalid one cycle later (OUT_REG = 1).
- Byte lanes:
  - write 0xAABBCCDD to address 5 with wren = 4'b1111;
  - then write 0x11223344 with wren = 4'b0101;
  - read address 5 → 0xAA22CC44.
- Read-during-write: address 9 holds 0x1; write 0x2 to address 9 with a simultaneous read of 9. RDW_MODE 0 → 0x1; RDW_MODE 1 → 0x2.
- Clear mid-traffic (INIT_VAL = 0xDEADBEEF):
  - pulse clear, then attempt a write of 0x5 to address 3 during busy;
  - expect rvalid = 0 for reads issued during busy;
  - after busy falls, address 3 reads 0xDEADBEEF.
- Reset at pointer 20 of a clear pass: the pass restarts, and busy lasts SIZE cycles after release. No rvalid is asserted throughout.
- Back-to-back reads of addresses 0–7 on consecutive cycles with OUT_REG = 1: eight consecutive rvalid pulses, with data in address order.
